// File: rtl/reg_writeback_pkg.sv
// Shared datapath constants for the writeback stage: destination codes,
// FSM state encoding and default data width.
package reg_writeback_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] DEST_NONE = 2'b00;
    localparam logic [1:0] DEST_A    = 2'b01;
    localparam logic [1:0] DEST_B    = 2'b10;
    localparam logic [1:0] DEST_AB   = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/reg_writeback_flag_unit.sv
// Combinational Z/N/C flag generation from a result and its carry-out.
// Kept separate so other stages can derive flags the same way.
module flag_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             carry,
    output logic             z,
    output logic             n,
    output logic             c
);

    assign z = (data == '0);
    assign n = data[WIDTH-1];
    assign c = carry;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: accepts one ALU result per two cycles over valid/ready,
// stages it, then commits it to operand registers A/B, the status flags and
// the commit counter on the following edge.
//
// state  | meaning
// IDLE   | ready for a result; accept stages data and moves to COMMIT
// COMMIT | staged result written to A/B, flags and counter; back to IDLE
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [1:0]       wb_dest,
    input  logic             wb_carry,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic [7:0]       wb_count
);

    wb_state_t        state;
    wb_state_t        state_next;
    logic             load_stage;
    logic             do_commit;
    logic             ready_next;

    logic [WIDTH-1:0] stage_data;
    logic [1:0]       stage_dest;
    logic             stage_carry;

    logic             z_next;
    logic             n_next;
    logic             c_next;
    logic             write_a;
    logic             write_b;

    flag_unit #(.WIDTH(WIDTH)) u_flag_unit (
        .data  (stage_data),
        .carry (stage_carry),
        .z     (z_next),
        .n     (n_next),
        .c     (c_next)
    );

    assign write_a = (stage_dest == DEST_A) || (stage_dest == DEST_AB);
    assign write_b = (stage_dest == DEST_B) || (stage_dest == DEST_AB);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle controls; ready drops only for the commit cycle.
    always_comb begin
        state_next = state;
        load_stage = 1'b0;
        do_commit  = 1'b0;
        ready_next = 1'b1;
        case (state)
            IDLE: begin
                if (wb_valid && wb_ready) begin
                    load_stage = 1'b1;
                    ready_next = 1'b0;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                do_commit  = 1'b1;
                ready_next = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Staging, register/flag/counter commit and the registered ready output.
    // Reset during COMMIT wins, so a staged result is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_ready    <= 1'b0;
            stage_data  <= '0;
            stage_dest  <= DEST_NONE;
            stage_carry <= 1'b0;
            reg_a       <= '0;
            reg_b       <= '0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_c      <= 1'b0;
            wb_count    <= 8'd0;
        end else begin
            wb_ready <= ready_next;
            if (load_stage) begin
                stage_data  <= wb_data;
                stage_dest  <= wb_dest;
                stage_carry <= wb_carry;
            end
            if (do_commit) begin
                if (write_a) begin
                    reg_a <= stage_data;
                end
                if (write_b) begin
                    reg_b <= stage_data;
                end
                flag_z   <= z_next;
                flag_n   <= n_next;
                flag_c   <= c_next;
                wb_count <= wb_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed test-plan scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_reg_writeback;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_data;
    logic [1:0]       wb_dest;
    logic             wb_carry;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic [7:0]       wb_count;

    int n_checks;
    int n_fails;

    // Reference model: what is architecturally visible, plus whether a
    // result is waiting to be committed on the next edge.
    logic [7:0] m_a, m_b, m_count;
    logic       m_z, m_n, m_c, m_ready;
    logic       m_pending;
    logic [7:0] p_data;
    logic [1:0] p_dest;
    logic       p_carry;
    logic       m_accepted;

    reg_writeback #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_dest  (wb_dest),
        .wb_carry (wb_carry),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c),
        .wb_count (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge as seen by the model: a held result is committed,
    // otherwise an offered result is taken if the block is ready.
    task automatic model_edge();
        m_accepted = 1'b0;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_count = 0;
            m_z = 0; m_n = 0; m_c = 0;
            m_ready = 0; m_pending = 0;
        end else if (m_pending) begin
            if (p_dest[0]) m_a = p_data;
            if (p_dest[1]) m_b = p_data;
            m_z = (p_data == 8'd0);
            m_n = p_data[7];
            m_c = p_carry;
            m_count = m_count + 8'd1;
            m_pending = 0;
            m_ready = 1;
        end else if (wb_valid && m_ready) begin
            p_data = wb_data; p_dest = wb_dest; p_carry = wb_carry;
            m_pending = 1;
            m_ready = 0;
            m_accepted = 1'b1;
        end else begin
            m_ready = 1;
        end
    endtask

    task automatic check_model();
        chk("ready", {31'd0, wb_ready}, {31'd0, m_ready});
        chk("reg_a", {24'd0, reg_a}, {24'd0, m_a});
        chk("reg_b", {24'd0, reg_b}, {24'd0, m_b});
        chk("flag_z", {31'd0, flag_z}, {31'd0, m_z});
        chk("flag_n", {31'd0, flag_n}, {31'd0, m_n});
        chk("flag_c", {31'd0, flag_c}, {31'd0, m_c});
        chk("count", {24'd0, wb_count}, {24'd0, m_count});
    endtask

    // Called at a falling edge: drive inputs, take the rising edge, update
    // the model, then compare at the next falling edge.
    task automatic cycle(input logic rst, input logic valid, input logic [7:0] data,
                         input logic [1:0] dest, input logic carry);
        rst_n    = rst;
        wb_valid = valid;
        wb_data  = data;
        wb_dest  = dest;
        wb_carry = carry;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
            chk("rst_ready", {31'd0, wb_ready}, 32'd0);
            chk("rst_count", {24'd0, wb_count}, 32'd0);
        end
        cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("first_ready", {31'd0, wb_ready}, 32'd1);
    endtask

    logic [7:0] b2b_vals [3];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0; wb_valid = 1'b0; wb_data = '0; wb_dest = '0; wb_carry = 1'b0;
        m_a = 0; m_b = 0; m_count = 0; m_z = 0; m_n = 0; m_c = 0;
        m_ready = 0; m_pending = 0; p_data = 0; p_dest = 0; p_carry = 0; m_accepted = 0;
        @(negedge clk);

        do_reset();
        chk("rst_reg_a", {24'd0, reg_a}, 32'd0);
        chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);

        // Write A
        cycle(1'b1, 1'b1, 8'h5A, 2'b01, 1'b0);
        chk("wa_ready_low", {31'd0, wb_ready}, 32'd0);
        chk("wa_not_yet", {24'd0, reg_a}, 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("wa_reg_a", {24'd0, reg_a}, 32'h5A);
        chk("wa_reg_b", {24'd0, reg_b}, 32'h00);
        chk("wa_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        chk("wa_count", {24'd0, wb_count}, 32'd1);
        chk("wa_ready_back", {31'd0, wb_ready}, 32'd1);

        // Write both, then no destination
        cycle(1'b1, 1'b1, 8'h80, 2'b11, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("ab_reg_a", {24'd0, reg_a}, 32'h80);
        chk("ab_reg_b", {24'd0, reg_b}, 32'h80);
        chk("ab_flags", {29'd0, flag_z, flag_n, flag_c}, 32'b011);
        cycle(1'b1, 1'b1, 8'h00, 2'b00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("nd_reg_a", {24'd0, reg_a}, 32'h80);
        chk("nd_reg_b", {24'd0, reg_b}, 32'h80);
        chk("nd_flags", {29'd0, flag_z, flag_n, flag_c}, 32'b100);
        chk("nd_count", {24'd0, wb_count}, 32'd3);

        // Back-to-back with valid held high
        do_reset();
        b2b_vals[0] = 8'h11; b2b_vals[1] = 8'h22; b2b_vals[2] = 8'h33;
        begin
            int idx;
            int cycles;
            idx = 0;
            cycles = 0;
            while (idx < 3 && cycles < 20) begin
                cycle(1'b1, 1'b1, b2b_vals[idx], 2'b01, 1'b0);
                cycles++;
                if (m_accepted) idx++;
            end
            cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
            cycles++;
            chk("b2b_cycles", cycles, 32'd6);
        end
        chk("b2b_reg_a", {24'd0, reg_a}, 32'h33);
        chk("b2b_count", {24'd0, wb_count}, 32'd3);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b1, i[7:0], i[1:0], i[0]);
            cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
            if (i == 254) chk("cnt_255", {24'd0, wb_count}, 32'd255);
        end
        chk("cnt_wrap", {24'd0, wb_count}, 32'd0);

        // Reset during COMMIT
        cycle(1'b1, 1'b1, 8'hFF, 2'b10, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("mid_reg_b", {24'd0, reg_b}, 32'd0);
        chk("mid_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        chk("mid_count", {24'd0, wb_count}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("mid_no_commit_b", {24'd0, reg_b}, 32'd0);
        chk("mid_no_commit_cnt", {24'd0, wb_count}, 32'd0);

        // Randomized traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1),
                  8'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
